// File: rtl/iob_2p_assim_mem_rd_stream.sv
// Burst reader: streams len words from a synchronous memory read port into a valid/ready
// output through a 2-entry buffer. Define RD_STREAM_LAST_EN to add the m_last output.
module iob_2p_assim_mem_rd_stream #(
  parameter int R_DATA_W = 8,
  parameter int R_ADDR_W = 7
) (
  input  logic                rclk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [R_ADDR_W-1:0] base_addr,
  input  logic [R_ADDR_W:0]   len,
  output logic                busy,
  output logic                done,
  output logic                mem_r_en,
  output logic [R_ADDR_W-1:0] mem_r_addr,
  input  logic [R_DATA_W-1:0] mem_data_out,
  output logic                m_valid,
  output logic [R_DATA_W-1:0] m_data,
  input  logic                m_ready
`ifdef RD_STREAM_LAST_EN
  ,
  output logic                m_last
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [R_ADDR_W-1:0] ADDR_ONE = {{(R_ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [R_ADDR_W:0]   REM_ONE  = {{R_ADDR_W{1'b0}}, 1'b1};
  localparam logic [R_ADDR_W:0]   REM_ZERO = {(R_ADDR_W+1){1'b0}};

  state_t                state_q, state_d;
  logic [R_ADDR_W-1:0]   addr_q, addr_d;
  logic [R_ADDR_W:0]     rem_q, rem_d;
  logic                  inflight_q;
  logic                  zero_done_q, zero_done_d;
  logic [1:0]            occ_q, occ_d;
  logic                  rd_ptr_q, wr_ptr_q;
  logic [R_DATA_W-1:0]   buf0_q, buf1_q;

  logic                  rd_en_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  drain_done_s;

  assign push_s       = inflight_q;
  assign m_valid      = (occ_q != 2'd0);
  assign pop_s        = m_valid & m_ready;
  assign m_data       = rd_ptr_q ? buf1_q : buf0_q;
  assign mem_r_en     = rd_en_s;
  assign mem_r_addr   = addr_q;
  assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign drain_done_s = (state_q == ST_DRAIN) && (occ_q == 2'd0) && !inflight_q;
  assign done         = zero_done_q | drain_done_s;

  // A read may only issue if its word is guaranteed a buffer slot when it lands.
  assign rd_en_s = (state_q == ST_RUN) && (rem_q != REM_ZERO) &&
                   (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_s}));

  // Next-state, address and remaining-count logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    zero_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != REM_ZERO) begin
            addr_d  = base_addr;
            rem_d   = len;
            state_d = ST_RUN;
          end else begin
            zero_done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (rd_en_s) begin
          addr_d = addr_q + ADDR_ONE;
          rem_d  = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end else if (rem_q == REM_ZERO) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Buffer occupancy: a simultaneous push and pop cancel out.
  always_comb begin
    occ_d = occ_q;
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Control state and the 2-entry output buffer.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= {R_ADDR_W{1'b0}};
      rem_q       <= REM_ZERO;
      inflight_q  <= 1'b0;
      zero_done_q <= 1'b0;
      occ_q       <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      buf0_q      <= {R_DATA_W{1'b0}};
      buf1_q      <= {R_DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      inflight_q  <= rd_en_s;
      zero_done_q <= zero_done_d;
      occ_q       <= occ_d;
      if (push_s) begin
        if (wr_ptr_q) begin
          buf1_q <= mem_data_out;
        end else begin
          buf0_q <= mem_data_out;
        end
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

`ifdef RD_STREAM_LAST_EN
  logic last_inflight_q;
  logic lbuf0_q, lbuf1_q;

  assign m_last = m_valid & (rd_ptr_q ? lbuf1_q : lbuf0_q);

  // The final read of a burst carries a last flag through the buffer alongside its data.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      last_inflight_q <= 1'b0;
      lbuf0_q         <= 1'b0;
      lbuf1_q         <= 1'b0;
    end else begin
      last_inflight_q <= rd_en_s && (rem_q == REM_ONE);
      if (push_s) begin
        if (wr_ptr_q) begin
          lbuf1_q <= last_inflight_q;
        end else begin
          lbuf0_q <= last_inflight_q;
        end
      end
    end
  end
`endif

endmodule

// File: doc/iob_2p_assim_mem_rd_stream.md
IOB_2P_ASSIM_MEM_RD_STREAM -- requirements
Module: iob_2p_assim_mem_rd_stream

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter R_DATA_W, default 8, SHALL set the narrow read-port data width.
REQ-003 Parameter R_ADDR_W, default 7, SHALL set the narrow read-port address width.
REQ-004 rclk  input  1  SHALL be the clock, shared with the memory read port.
REQ-005 rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-006 start  input  1  SHALL request a burst; it is sampled only in IDLE.
REQ-007 base_addr  input  R_ADDR_W  SHALL give the first read address, sampled with start.
REQ-008 len  input  R_ADDR_W+1  SHALL give the word count, 0..2^R_ADDR_W, sampled with start.
REQ-009 busy  output  1  SHALL be high in RUN and DRAIN.
REQ-010 done  output  1  SHALL be a one-cycle pulse marking burst completion.
REQ-011 mem_r_en  output  1  SHALL drive the memory read enable.
REQ-012 mem_r_addr  output  R_ADDR_W  SHALL drive the memory read address.
REQ-013 mem_data_out  input  R_DATA_W  SHALL carry memory read data, valid one cycle after mem_r_en.
REQ-014 m_valid, m_data (R_DATA_W), m_ready SHALL form the output stream: output, output, input.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-016 In IDLE, start with len!=0 SHALL load addr=base_addr, remaining=len and go to RUN.
REQ-017 In IDLE, start with len==0 SHALL pulse done on the next cycle and stay in IDLE.
REQ-018 start in RUN or DRAIN SHALL be ignored with no effect.
REQ-019 In RUN, mem_r_en SHALL be high when remaining>0 and occ+inflight-pop<2, where occ is the 2-entry output buffer count, inflight is a read issued the previous cycle, and pop=m_valid&m_ready.
REQ-020 Each issued read SHALL decrement remaining and increment addr modulo 2^R_ADDR_W (wrap 2^R_ADDR_W-1 -> 0).
REQ-021 When remaining reaches 0, the FSM SHALL go to DRAIN.
REQ-022 In DRAIN, with occ==0 and no read in flight, the FSM SHALL pulse done for one cycle and return to IDLE.
REQ-023 mem_data_out SHALL be captured into the buffer the cycle after its read is issued; no word SHALL ever be dropped or duplicated.
REQ-024 m_valid SHALL equal occ!=0; m_data SHALL be the oldest buffered word and SHALL stay stable while m_valid&!m_ready.
REQ-025 Latency: start sampled at edge k -> mem_r_en high in cycle k..k+1 -> m_valid high after edge k+2.
REQ-026 With m_ready held high, the block SHALL sustain one word per cycle.
REQ-027 A simultaneous push and pop SHALL leave occ unchanged.
REQ-028 mem_r_en SHALL be 0 in IDLE and DRAIN; mem_r_addr SHALL hold its last value when mem_r_en is 0.

Reset
REQ-029 rst_n low SHALL force IDLE, busy=0, done=0, mem_r_en=0, mem_r_addr=0, m_valid=0, m_data=0, occ=0, and clear the in-flight flag.
REQ-030 Reset mid-burst SHALL discard buffered and in-flight words with no done pulse.

Configuration
REQ-031 With macro RD_STREAM_LAST_EN defined, the block SHALL add output m_last (1 bit), high with the final word of a burst while it is at the buffer head, and reset to 0.
REQ-032 Without RD_STREAM_LAST_EN, port m_last SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Memory preloaded ram[i]=i; start, base_addr=0x10, len=4, m_ready=1 -> m_data 0x10,0x11,0x12,0x13 on 4 consecutive cycles, first after edge k+2; done one cycle after the last read drains.
REQ-034 base_addr=0x7E, len=4 -> mem_r_addr 0x7E,0x7F,0x00,0x01; data in that order.
REQ-035 len=8 with m_ready toggling 1,0,0,1,... -> 8 words in order, none lost; occ never exceeds 2; m_data stable while stalled.
REQ-036 start with len=0 -> no mem_r_en; done pulses once; busy stays 0.
REQ-037 rst_n low for 1 cycle after the 3rd word of a len=8 burst -> all outputs 0; a new start with base_addr=0, len=2 returns 0x00,0x01.
REQ-038 RD_STREAM_LAST_EN defined, len=3 -> m_last high only with the 3rd word; start pulsed mid-burst is ignored.
